// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, opcode constants and decode helper for the ROM bus sequencer
//
// Purpose: bus phase enumeration, I/O opcode constants and the two-word
//          instruction classifier used by the phase counter and the top.
// Ports:   none (package).

package bus_pkg;

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_A1   = 4'd1,
    PH_A2   = 4'd2,
    PH_A3   = 4'd3,
    PH_M1   = 4'd4,
    PH_M2   = 4'd5,
    PH_X1   = 4'd6,
    PH_X2   = 4'd7,
    PH_X3   = 4'd8
  } phase_e;

  localparam logic [3:0] OPR_IO  = 4'hE;
  localparam logic [3:0] OPA_WRR = 4'h2;
  localparam logic [3:0] OPA_RDR = 4'hA;
  localparam logic [3:0] OPR_SRC = 4'h2;

  // The word fetched in the following instruction cycle is an operand, not an opcode.
  // For OPR 2/3 only the even OPA forms (FIM, FIN) carry a second word; the odd
  // forms (SRC, JIN) are single-word.
  function automatic logic is_two_word(input logic [7:0] opcode);
    logic result;
    case (opcode[7:4])
      4'h1, 4'h4, 4'h5, 4'h7: result = 1'b1;
      4'h2, 4'h3:             result = ~opcode[0];
      default:                result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/bus_phase_counter.sv
// rtl/bus_phase_counter.sv - 8-phase instruction cycle tracker with sync anomaly detection
//
// Purpose: follows the CPU instruction cycle A1..X3, re-aligning to A1 whenever
//          sync is seen, and flags a sync that arrives early or is missing in X3.
// Ports:
//   clock_i        system clock, one bus phase per clock
//   reset_n_i      synchronous active-low reset
//   sync_i         CPU sync, high during X3
//   phase_o        current (registered) bus phase
//   sync_error_o   one-clock pulse in the phase following an anomaly

module bus_phase_counter
  import bus_pkg::*;
(
  input  logic   clock_i,
  input  logic   reset_n_i,
  input  logic   sync_i,
  output phase_e phase_o,
  output logic   sync_error_o
);

  phase_e phase_q, phase_d;
  logic   sync_error_q, sync_error_d;

  always_comb begin
    phase_d      = phase_q;
    sync_error_d = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (sync_i) phase_d = PH_A1;
      end
      PH_X3: begin
        // Always wrap; a missing sync is reported but the cycle still restarts.
        phase_d      = PH_A1;
        sync_error_d = ~sync_i;
      end
      default: begin
        if (sync_i) begin
          phase_d      = PH_A1;
          sync_error_d = 1'b1;
        end else begin
          case (phase_q)
            PH_A1:   phase_d = PH_A2;
            PH_A2:   phase_d = PH_A3;
            PH_A3:   phase_d = PH_M1;
            PH_M1:   phase_d = PH_M2;
            PH_M2:   phase_d = PH_X1;
            PH_X1:   phase_d = PH_X2;
            PH_X2:   phase_d = PH_X3;
            default: phase_d = PH_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      phase_q      <= PH_IDLE;
      sync_error_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign phase_o      = phase_q;
  assign sync_error_o = sync_error_q;

endmodule

// File: rtl/rom_bus_controller.sv
// rtl/rom_bus_controller.sv - memory-side sequencer for the shared 4-bit CPU bus
//
// Purpose: assembles the 12-bit fetch address from A1..A3, drives the opcode
//          nibbles from program ROM in M1/M2, and services SRC/WRR/RDR for one
//          4-bit I/O port.
// Ports:
//   clock, reset_n     clock and synchronous active-low reset
//   sync               CPU sync (high in X3)
//   data_in            bus value driven by the CPU
//   data_out, data_oe  bus value and drive enable from this block
//   rom_addr, rom_rd   registered fetch address and ROM read strobe (M1/M2)
//   rom_data           combinational ROM word for rom_addr
//   io_in, io_out      input port (RDR) and output port register (WRR)
//   sync_error         one-clock pulse on a sync anomaly

module rom_bus_controller
  import bus_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sync,
  input  logic [3:0]  data_in,
  output logic [3:0]  data_out,
  output logic        data_oe,
  output logic [11:0] rom_addr,
  output logic        rom_rd,
  input  logic [7:0]  rom_data,
  input  logic [3:0]  io_in,
  output logic [3:0]  io_out,
  output logic        sync_error
);

  phase_e phase;

  bus_phase_counter u_phase (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .sync_i       (sync),
    .phase_o      (phase),
    .sync_error_o (sync_error)
  );

  logic [3:0]  addr_lo_q,     addr_lo_d;
  logic [3:0]  addr_mid_q,    addr_mid_d;
  logic [11:0] rom_addr_q,    rom_addr_d;
  logic [7:0]  opcode_q,      opcode_d;
  logic        second_word_q, second_word_d;
  logic        selected_q,    selected_d;
  logic [3:0]  io_out_q,      io_out_d;

  // I/O decode applies only to a genuine opcode, never to an operand word.
  logic is_src, is_wrr, is_rdr;
  assign is_src = ~second_word_q && (opcode_q[7:4] == OPR_SRC) && opcode_q[0];
  assign is_wrr = ~second_word_q && (opcode_q == {OPR_IO, OPA_WRR});
  assign is_rdr = ~second_word_q && (opcode_q == {OPR_IO, OPA_RDR});

  always_comb begin
    addr_lo_d     = addr_lo_q;
    addr_mid_d    = addr_mid_q;
    rom_addr_d    = rom_addr_q;
    opcode_d      = opcode_q;
    second_word_d = second_word_q;
    selected_d    = selected_q;
    io_out_d      = io_out_q;
    case (phase)
      PH_A1: addr_lo_d  = data_in;
      PH_A2: addr_mid_d = data_in;
      PH_A3: begin
        // A resync in A3 abandons the partial address instead of publishing it.
        if (!sync) rom_addr_d = {data_in, addr_mid_q, addr_lo_q};
      end
      PH_M1: opcode_d = rom_data;
      PH_X2: begin
        if (is_src)                selected_d = (data_in == CHIP_ID);
        if (is_wrr && selected_q)  io_out_d   = data_in;
      end
      PH_X3: begin
        // Only a completed cycle updates the flag, so an interrupted cycle keeps it pending.
        second_word_d = second_word_q ? 1'b0 : is_two_word(opcode_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_lo_q     <= 4'h0;
      addr_mid_q    <= 4'h0;
      rom_addr_q    <= 12'h000;
      opcode_q      <= 8'h00;
      second_word_q <= 1'b0;
      selected_q    <= 1'b0;
      io_out_q      <= 4'h0;
    end else begin
      addr_lo_q     <= addr_lo_d;
      addr_mid_q    <= addr_mid_d;
      rom_addr_q    <= rom_addr_d;
      opcode_q      <= opcode_d;
      second_word_q <= second_word_d;
      selected_q    <= selected_d;
      io_out_q      <= io_out_d;
    end
  end

  // Bus drive depends only on registered phase/opcode/selected; data paths
  // come straight from rom_data and io_in.
  always_comb begin
    data_oe  = 1'b0;
    data_out = 4'h0;
    case (phase)
      PH_M1: begin
        data_oe  = 1'b1;
        data_out = rom_data[7:4];
      end
      PH_M2: begin
        data_oe  = 1'b1;
        data_out = rom_data[3:0];
      end
      PH_X2: begin
        if (is_rdr && selected_q) begin
          data_oe  = 1'b1;
          data_out = io_in;
        end
      end
      default: ;
    endcase
  end

  assign rom_rd   = (phase == PH_M1) || (phase == PH_M2);
  assign rom_addr = rom_addr_q;
  assign io_out   = io_out_q;

endmodule
